// File: rtl/ahb_lite_master.sv
// ahb_lite_master
//   Single-outstanding-transfer AHB-Lite initiator. Turns a valid/ready
//   command into one NONSEQ SINGLE transfer on a 7-bit address, 32-bit data
//   bus, placing/extracting byte and halfword lanes, absorbing wait states
//   and the two-cycle ERROR response.
//
// Ports:
//   clk, n_rst            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only when idle)
//   cmd_write/addr/size   command attributes (size 3 is illegal)
//   cmd_wdata             right-justified write data
//   resp_valid/error      one-cycle completion pulse, error flag
//   resp_rdata            right-justified, zero-extended read data
//   wait_count            DATA-phase wait states of the last transfer
//   hsel..hwdata          AHB-Lite initiator outputs (all registered)
//   hrdata/hready/hresp   AHB-Lite slave responses
module ahb_lite_master #(
  parameter logic [7:0] MAX_WAIT = 8'd255
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [6:0]  cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic [7:0]  wait_count,
  output logic        hsel,
  output logic [6:0]  haddr,
  output logic [1:0]  htrans,
  output logic [1:0]  hsize,
  output logic        hwrite,
  output logic [2:0]  hburst,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic        cmd_legal;
  logic [31:0] lane_q, lane_d;

  logic        hsel_d, hwrite_d, resp_valid_d, resp_error_d;
  logic [6:0]  haddr_d;
  logic [1:0]  htrans_d, hsize_d;
  logic [31:0] hwdata_d, resp_rdata_d;
  logic [7:0]  wait_count_d;

  function automatic logic [31:0] place_lanes(input logic [1:0] size,
                                              input logic [1:0] lo,
                                              input logic [31:0] data);
    case (size)
      2'd0:    place_lanes = 32'(data[7:0]) << {lo, 3'b000};
      2'd1:    place_lanes = lo[1] ? {data[15:0], 16'h0000} : {16'h0000, data[15:0]};
      2'd2:    place_lanes = data;
      default: place_lanes = '0;
    endcase
  endfunction

  function automatic logic [31:0] extract_lanes(input logic [1:0] size,
                                                input logic [1:0] lo,
                                                input logic [31:0] data);
    logic [31:0] shifted;
    shifted = data >> {lo, 3'b000};
    case (size)
      2'd0:    extract_lanes = {24'h000000, shifted[7:0]};
      2'd1:    extract_lanes = lo[1] ? {16'h0000, data[31:16]} : {16'h0000, data[15:0]};
      2'd2:    extract_lanes = data;
      default: extract_lanes = '0;
    endcase
  endfunction

  assign cmd_ready = (state == IDLE);
  assign hburst    = 3'b000;

  always_comb begin
    case (cmd_size)
      2'd0:    cmd_legal = 1'b1;
      2'd1:    cmd_legal = ~cmd_addr[0];
      2'd2:    cmd_legal = (cmd_addr[1:0] == 2'b00);
      default: cmd_legal = 1'b0;
    endcase
  end

  // State and all registered outputs.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      hsel       <= 1'b0;
      haddr      <= '0;
      htrans     <= 2'b00;
      hsize      <= 2'b00;
      hwrite     <= 1'b0;
      hwdata     <= '0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
      wait_count <= '0;
      lane_q     <= '0;
    end else begin
      state      <= state_next;
      hsel       <= hsel_d;
      haddr      <= haddr_d;
      htrans     <= htrans_d;
      hsize      <= hsize_d;
      hwrite     <= hwrite_d;
      hwdata     <= hwdata_d;
      resp_valid <= resp_valid_d;
      resp_error <= resp_error_d;
      resp_rdata <= resp_rdata_d;
      wait_count <= wait_count_d;
      lane_q     <= lane_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (cmd_valid && cmd_legal) state_next = ADDR;
      ADDR: if (hready) state_next = DATA;
      DATA: begin
        if (hresp)       state_next = hready ? IDLE : ERR;
        else if (hready) state_next = IDLE;
      end
      ERR:  if (hready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values for the registered outputs. haddr/hsize/hwrite double as the
  // latched command; lane_q holds write data already placed on its lanes.
  always_comb begin
    hsel_d       = 1'b0;
    htrans_d     = 2'b00;
    haddr_d      = haddr;
    hsize_d      = hsize;
    hwrite_d     = hwrite;
    hwdata_d     = '0;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = resp_rdata;
    wait_count_d = wait_count;
    lane_d       = lane_q;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_legal) begin
            hsel_d       = 1'b1;
            htrans_d     = 2'b10;
            haddr_d      = cmd_addr;
            hsize_d      = cmd_size;
            hwrite_d     = cmd_write;
            wait_count_d = '0;
            lane_d       = place_lanes(cmd_size, cmd_addr[1:0], cmd_wdata);
          end else begin
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = '0;
          end
        end
      end
      ADDR: begin
        if (hready) begin
          hwdata_d = hwrite ? lane_q : '0;
        end else begin
          hsel_d   = 1'b1;
          htrans_d = 2'b10;
        end
      end
      DATA: begin
        if (hresp) begin
          // A single-cycle ERROR (hready=1) completes as an error at once.
          if (hready) begin
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = '0;
          end
        end else if (hready) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = hwrite ? '0 : extract_lanes(hsize, haddr[1:0], hrdata);
        end else begin
          hwdata_d = hwrite ? lane_q : '0;
          if (wait_count != MAX_WAIT) wait_count_d = wait_count + 8'd1;
        end
      end
      ERR: begin
        if (hready) begin
          resp_valid_d = 1'b1;
          resp_error_d = 1'b1;
          resp_rdata_d = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master
//   Directed self-checking bench for ahb_lite_master. Inputs are driven and
//   outputs sampled 1 time unit after each rising edge.
module tb_ahb_lite_master;

  logic        clk;
  logic        n_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [6:0]  cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;
  logic [7:0]  wait_count;
  logic        hsel;
  logic [6:0]  haddr;
  logic [1:0]  htrans;
  logic [1:0]  hsize;
  logic        hwrite;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ahb_lite_master #(.MAX_WAIT(8'd255)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_size   (cmd_size),
    .cmd_wdata  (cmd_wdata),
    .resp_valid (resp_valid),
    .resp_error (resp_error),
    .resp_rdata (resp_rdata),
    .wait_count (wait_count),
    .hsel       (hsel),
    .haddr      (haddr),
    .htrans     (htrans),
    .hsize      (hsize),
    .hwrite     (hwrite),
    .hburst     (hburst),
    .hwdata     (hwdata),
    .hrdata     (hrdata),
    .hready     (hready),
    .hresp      (hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for exactly one edge; returns in the cycle after it.
  task automatic issue(input logic w, input logic [6:0] a, input logic [1:0] s,
                       input logic [31:0] d);
    check("cmd_ready_before_issue", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [6:0] ill_addr [3];
  logic [1:0] ill_size [3];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    ill_addr = '{7'h00, 7'h01, 7'h03};
    ill_size = '{2'd3, 2'd2, 2'd1};

    n_rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_size = '0; cmd_wdata = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_hsel",   32'(hsel), 0);
    check("rst_htrans", 32'(htrans), 0);
    check("rst_haddr",  32'(haddr), 0);
    check("rst_hsize",  32'(hsize), 0);
    check("rst_hwrite", 32'(hwrite), 0);
    check("rst_hburst", 32'(hburst), 0);
    check("rst_hwdata", hwdata, 0);
    check("rst_rvalid", 32'(resp_valid), 0);
    check("rst_rerror", 32'(resp_error), 0);
    check("rst_rdata",  resp_rdata, 0);
    check("rst_wait",   32'(wait_count), 0);
    n_rst = 1'b1;
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 1);

    // Word read at 0x04, no waits
    hrdata = 32'hDEADBEEF;
    issue(1'b0, 7'h04, 2'd2, 32'h0);
    check("rd_c1_hsel",   32'(hsel), 1);
    check("rd_c1_htrans", 32'(htrans), 2);
    check("rd_c1_haddr",  32'(haddr), 32'h04);
    check("rd_c1_hsize",  32'(hsize), 2);
    check("rd_c1_hwrite", 32'(hwrite), 0);
    check("rd_c1_ready",  32'(cmd_ready), 0);
    check("rd_c1_rvalid", 32'(resp_valid), 0);
    tick();
    check("rd_c2_htrans", 32'(htrans), 0);
    check("rd_c2_hsel",   32'(hsel), 0);
    check("rd_c2_rvalid", 32'(resp_valid), 0);
    tick();
    hrdata = 32'h0;
    check("rd_c3_rvalid", 32'(resp_valid), 1);
    check("rd_c3_rdata",  resp_rdata, 32'hDEADBEEF);
    check("rd_c3_rerror", 32'(resp_error), 0);
    check("rd_c3_wait",   32'(wait_count), 0);
    check("rd_c3_ready",  32'(cmd_ready), 1);
    tick();
    check("rd_c4_rvalid", 32'(resp_valid), 0);

    // Byte write at 0x4B then halfword write at 0x4A
    issue(1'b1, 7'h4B, 2'd0, 32'h000000A5);
    check("bw_hsize",  32'(hsize), 0);
    check("bw_haddr",  32'(haddr), 32'h4B);
    check("bw_hwrite", 32'(hwrite), 1);
    check("bw_htrans", 32'(htrans), 2);
    tick();
    check("bw_hwdata", hwdata, 32'hA5000000);
    tick();
    check("bw_rvalid", 32'(resp_valid), 1);
    check("bw_rerror", 32'(resp_error), 0);
    check("bw_rdata",  resp_rdata, 0);
    check("bw_hwdata_idle", hwdata, 0);
    issue(1'b1, 7'h4A, 2'd1, 32'h00001234);
    check("hw_haddr", 32'(haddr), 32'h4A);
    check("hw_hsize", 32'(hsize), 1);
    tick();
    check("hw_hwdata", hwdata, 32'h12340000);
    tick();
    check("hw_rvalid", 32'(resp_valid), 1);

    // Halfword read at 0x02 with 3 DATA wait states
    hrdata = 32'hCAFE0000;
    issue(1'b0, 7'h02, 2'd1, 32'h0);
    tick();
    hready = 1'b0;
    tick();
    check("hr_c3_rvalid", 32'(resp_valid), 0);
    check("hr_c3_wait",   32'(wait_count), 1);
    tick();
    tick();
    check("hr_c5_rvalid", 32'(resp_valid), 0);
    check("hr_c5_wait",   32'(wait_count), 3);
    hready = 1'b1;
    tick();
    check("hr_c6_rvalid", 32'(resp_valid), 1);
    check("hr_c6_rdata",  resp_rdata, 32'h0000CAFE);
    check("hr_c6_wait",   32'(wait_count), 3);
    check("hr_c6_rerror", 32'(resp_error), 0);
    tick();
    check("hr_c7_rvalid", 32'(resp_valid), 0);

    // Word read with one ADDR-phase wait (not counted in wait_count)
    hrdata = 32'h87654321;
    issue(1'b0, 7'h10, 2'd2, 32'h0);
    hready = 1'b0;
    tick();
    check("aw_c2_htrans", 32'(htrans), 2);
    check("aw_c2_hsel",   32'(hsel), 1);
    check("aw_c2_haddr",  32'(haddr), 32'h10);
    hready = 1'b1;
    tick();
    check("aw_c3_htrans", 32'(htrans), 0);
    check("aw_c3_rvalid", 32'(resp_valid), 0);
    tick();
    check("aw_c4_rvalid", 32'(resp_valid), 1);
    check("aw_c4_rdata",  resp_rdata, 32'h87654321);
    check("aw_c4_wait",   32'(wait_count), 0);

    // Write with two-cycle ERROR response
    issue(1'b1, 7'h10, 2'd2, 32'h11223344);
    tick();
    check("er_c2_hwdata", hwdata, 32'h11223344);
    check("er_c2_htrans", 32'(htrans), 0);
    hresp = 1'b1; hready = 1'b0;
    tick();
    check("er_c3_htrans", 32'(htrans), 0);
    check("er_c3_hsel",   32'(hsel), 0);
    check("er_c3_rvalid", 32'(resp_valid), 0);
    hready = 1'b1;
    tick();
    hresp = 1'b0;
    check("er_c4_rvalid", 32'(resp_valid), 1);
    check("er_c4_rerror", 32'(resp_error), 1);
    check("er_c4_htrans", 32'(htrans), 0);
    hrdata = 32'h55AA0FF0;
    issue(1'b0, 7'h20, 2'd2, 32'h0);
    check("er_next_htrans", 32'(htrans), 2);
    tick();
    tick();
    check("er_next_rvalid", 32'(resp_valid), 1);
    check("er_next_rerror", 32'(resp_error), 0);
    check("er_next_rdata",  resp_rdata, 32'h55AA0FF0);

    // Illegal commands
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, ill_addr[i], ill_size[i], 32'h0);
      check("il_rvalid", 32'(resp_valid), 1);
      check("il_rerror", 32'(resp_error), 1);
      check("il_rdata",  resp_rdata, 0);
      check("il_hsel",   32'(hsel), 0);
      check("il_htrans", 32'(htrans), 0);
      check("il_ready",  32'(cmd_ready), 1);
      tick();
      check("il_rvalid_off", 32'(resp_valid), 0);
      check("il_hsel_off",   32'(hsel), 0);
    end

    // Reset during DATA phase, then a fresh byte read
    hrdata = 32'h0BADF00D;
    issue(1'b0, 7'h08, 2'd2, 32'h0);
    tick();
    n_rst = 1'b0;
    tick();
    check("mr_htrans", 32'(htrans), 0);
    check("mr_hsel",   32'(hsel), 0);
    check("mr_rvalid", 32'(resp_valid), 0);
    check("mr_haddr",  32'(haddr), 0);
    n_rst = 1'b1;
    tick();
    check("mr_rvalid_after", 32'(resp_valid), 0);
    check("mr_ready_after",  32'(cmd_ready), 1);
    hrdata = 32'h13579BDF;
    issue(1'b0, 7'h0D, 2'd0, 32'h0);
    tick();
    tick();
    check("mr_new_rvalid", 32'(resp_valid), 1);
    check("mr_new_rdata",  resp_rdata, 32'h0000009B);
    check("mr_new_rerror", 32'(resp_error), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
